// File: rtl/sysid_checker.sv
// sysid_checker: reads the ID word (address 0) and the build timestamp
// (address 1) from a system-ID slave, compares them with the expected
// values, retries a bounded number of times on mismatch and latches a
// pass/fail verdict until the next accepted start or reset.
//
// Handshake: start is a single-cycle request, accepted only when busy is low
// (IDLE, or DONE once the verdict is latched); a start seen while busy is
// dropped, never queued. busy rises on the edge that accepts start. The
// verdict appears in one cycle: done, pass and fail_id/fail_ts rise together
// on the same edge that drops busy.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID  = 32'd0,
   parameter logic [31:0] EXPECTED_TS  = 32'd1419253882,
   parameter int unsigned READ_LATENCY = 0,
   parameter int unsigned RETRIES      = 2,
   parameter bit          AUTO_START   = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        sysid_address,
   input  logic [31:0] sysid_readdata,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        fail_id,
   output logic        fail_ts,
   output logic [2:0]  attempts,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_ID = 3'd1,
      ST_RD_TS = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [3:0] LAT = 4'(READ_LATENCY);
   localparam logic [2:0] RET = 3'(RETRIES);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        auto_q, auto_d;
   logic        addr_q, addr_d;
   logic [31:0] id_q, id_d;
   logic [31:0] ts_q, ts_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        fid_q, fid_d;
   logic        fts_q, fts_d;
   logic [2:0]  att_q, att_d;

   logic        id_ok, ts_ok, launch;

   // State and result registers; reset abandons any check in flight and
   // re-arms the automatic check.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         auto_q  <= AUTO_START;
         addr_q  <= 1'b0;
         id_q    <= 32'd0;
         ts_q    <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fid_q   <= 1'b0;
         fts_q   <= 1'b0;
         att_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         auto_q  <= auto_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         ts_q    <= ts_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fid_q   <= fid_d;
         fts_q   <= fts_d;
         att_q   <= att_d;
      end
   end

   assign id_ok  = (id_q == EXPECTED_ID);
   assign ts_ok  = (ts_q == EXPECTED_TS);
   // DONE only accepts start after the verdict is latched (busy low).
   assign launch = ((state_q == ST_IDLE) && (start || auto_q)) ||
                   ((state_q == ST_DONE) && !busy_q && start);

   // Next-state logic: read sequencing, compare/retry and verdict latching.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      auto_d  = auto_q;
      id_d    = id_q;
      ts_d    = ts_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      fid_d   = fid_q;
      fts_d   = fts_q;
      att_d   = att_q;

      case (state_q)
         ST_IDLE: ;
         ST_RD_ID: begin
            if (cnt_q == LAT) begin
               id_d    = sysid_readdata;
               cnt_d   = 4'd0;
               state_d = ST_RD_TS;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RD_TS: begin
            if (cnt_q == LAT) begin
               ts_d    = sysid_readdata;
               cnt_d   = 4'd0;
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_CHECK: begin
            if (id_ok && ts_ok) begin
               state_d = ST_DONE;
            end else if (att_q < RET) begin
               att_d   = att_q + 3'd1;
               cnt_d   = 4'd0;
               state_d = ST_RD_ID;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // First DONE cycle: publish the verdict of the final attempt.
            if (busy_q) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               pass_d = id_ok && ts_ok;
               fid_d  = !id_ok;
               fts_d  = !ts_ok;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (launch) begin
         state_d = ST_RD_ID;
         cnt_d   = 4'd0;
         auto_d  = 1'b0;
         busy_d  = 1'b1;
         done_d  = 1'b0;
         pass_d  = 1'b0;
         fid_d   = 1'b0;
         fts_d   = 1'b0;
         att_d   = 3'd0;
      end
   end

   // Address is registered and only selects the timestamp while in RD_TS.
   always_comb begin
      addr_d = (state_d == ST_RD_TS);
   end

   assign sysid_address = addr_q;
   assign id_value      = id_q;
   assign ts_value      = ts_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign fail_id       = fid_q;
   assign fail_ts       = fts_q;
   assign attempts      = att_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: a default-latency instance driven by a table of
// slave behaviours, and a READ_LATENCY=3 instance with a slow slave model.
module tb_sysid_checker;

   localparam logic [31:0] TS_OK  = 32'd1419253882;
   localparam logic [31:0] TS_BAD = 32'd1419253881;
   localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

   int checks = 0;
   int errors = 0;

   // ---------------- clock ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- DUT 0: READ_LATENCY = 0 ----------------
   logic        rst0_n, start0, addr0;
   logic [31:0] rd0, id0, ts0;
   logic        busy0, done0, pass0, fid0, fts0;
   logic [2:0]  att0, st0;

   sysid_checker dut0 (
      .clock(clock), .reset_n(rst0_n), .start(start0),
      .sysid_address(addr0), .sysid_readdata(rd0),
      .id_value(id0), .ts_value(ts0), .busy(busy0), .done(done0),
      .pass(pass0), .fail_id(fid0), .fail_ts(fts0),
      .attempts(att0), .dbg_state(st0)
   );

   // Slave model 0. mode: 0 good, 1 ts always bad, 2 ts bad on first pair,
   // 3 id always bad, 4 both always bad. A read pair ends when address falls.
   int mode = 0;
   int pairs0 = 0;
   int pair_base = 0;
   logic [31:0] id_word, ts_word;
   always @(negedge addr0) pairs0 <= pairs0 + 1;
   assign id_word = (mode == 3 || mode == 4) ? 32'd5 : 32'd0;
   assign ts_word = (mode == 1 || mode == 4 || (mode == 2 && pairs0 == pair_base))
                    ? TS_BAD : TS_OK;
   assign rd0 = addr0 ? ts_word : id_word;

   // ---------------- DUT 3: READ_LATENCY = 3 ----------------
   logic        rst3_n, start3, addr3;
   logic [31:0] rd3, id3, ts3;
   logic        busy3, done3, pass3, fid3, fts3;
   logic [2:0]  att3, st3;

   sysid_checker #(.READ_LATENCY(3)) dut3 (
      .clock(clock), .reset_n(rst3_n), .start(start3),
      .sysid_address(addr3), .sysid_readdata(rd3),
      .id_value(id3), .ts_value(ts3), .busy(busy3), .done(done3),
      .pass(pass3), .fail_id(fid3), .fail_ts(fts3),
      .attempts(att3), .dbg_state(st3)
   );

   // Slow slave: data is valid only once the address has been stable for
   // three sampled cycles; before that it returns junk.
   logic last_addr3 = 1'b0;
   int   age3 = 100;
   always @(posedge clock) begin
      last_addr3 <= addr3;
      age3 <= (addr3 != last_addr3) ? 1 : ((age3 < 100) ? age3 + 1 : age3);
   end
   assign rd3 = (age3 >= 3 && addr3 == last_addr3) ? (addr3 ? TS_OK : 32'd0) : JUNK;

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
      end
   endtask

   // Structural invariants, checked every cycle away from the active edge.
   always @(negedge clock) begin
      chk("done_implies_idle0", 32'(done0 && busy0), 32'd0);
      chk("pass_vs_fail0", 32'(pass0 && (fid0 || fts0)), 32'd0);
      chk("done_implies_idle3", 32'(done3 && busy3), 32'd0);
      chk("pass_vs_fail3", 32'(pass3 && (fid3 || fts3)), 32'd0);
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start0();
      @(negedge clock) start0 = 1'b1;
      @(posedge clock) #1 start0 = 1'b0;
   endtask

   // Counts edges (after the accepting edge) until done0 rises; bounded.
   task automatic wait_done0(output int n);
      n = 0;
      while (n < 40) begin
         @(posedge clock) #1;
         n++;
         if (done0) break;
      end
   endtask

   task automatic chk_zero0(input string tag);
      chk({tag, "_addr"},  32'(addr0), 32'd0);
      chk({tag, "_id"},    id0, 32'd0);
      chk({tag, "_ts"},    ts0, 32'd0);
      chk({tag, "_busy"},  32'(busy0), 32'd0);
      chk({tag, "_done"},  32'(done0), 32'd0);
      chk({tag, "_pass"},  32'(pass0), 32'd0);
      chk({tag, "_fid"},   32'(fid0), 32'd0);
      chk({tag, "_fts"},   32'(fts0), 32'd0);
      chk({tag, "_att"},   32'(att0), 32'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          mode;
      logic        pass;
      logic        fid;
      logic        fts;
      logic [2:0]  att;
      int          cycles;
      logic [31:0] id;
      logic [31:0] ts;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n;
      int done_k;

      vecs[0] = '{0, 1'b1, 1'b0, 1'b0, 3'd0,  4, 32'd0, TS_OK};
      vecs[1] = '{1, 1'b0, 1'b0, 1'b1, 3'd2, 10, 32'd0, TS_BAD};
      vecs[2] = '{2, 1'b1, 1'b0, 1'b0, 3'd1,  7, 32'd0, TS_OK};
      vecs[3] = '{3, 1'b0, 1'b1, 1'b0, 3'd2, 10, 32'd5, TS_OK};
      vecs[4] = '{4, 1'b0, 1'b1, 1'b1, 3'd2, 10, 32'd5, TS_BAD};
      vecs[5] = '{0, 1'b1, 1'b0, 1'b0, 3'd0,  4, 32'd0, TS_OK};

      rst0_n = 1'b0; rst3_n = 1'b0; start0 = 1'b0; start3 = 1'b0;
      mode = 0;

      // Reset values.
      repeat (2) @(posedge clock);
      #1 chk_zero0("reset");

      // Auto-start after reset release: busy on the first edge, done 4 later.
      @(negedge clock) rst0_n = 1'b1;
      @(posedge clock) #1;
      chk("auto_busy", 32'(busy0), 32'd1);
      chk("auto_done_low", 32'(done0), 32'd0);
      wait_done0(n);
      chk("auto_latency", n, 32'd4);
      chk("auto_pass", 32'(pass0), 32'd1);
      chk("auto_att", 32'(att0), 32'd0);
      chk("auto_ts", ts0, TS_OK);

      // Table of slave behaviours, each launched by start from DONE.
      for (int i = 0; i < 6; i++) begin
         pair_base = pairs0;
         mode = vecs[i].mode;
         pulse_start0();
         chk($sformatf("v%0d_busy", i), 32'(busy0), 32'd1);
         chk($sformatf("v%0d_cleared", i), 32'({done0, pass0, fid0, fts0, att0}), 32'd0);
         wait_done0(n);
         chk($sformatf("v%0d_latency", i), n, vecs[i].cycles);
         chk($sformatf("v%0d_pass", i), 32'(pass0), 32'(vecs[i].pass));
         chk($sformatf("v%0d_fail_id", i), 32'(fid0), 32'(vecs[i].fid));
         chk($sformatf("v%0d_fail_ts", i), 32'(fts0), 32'(vecs[i].fts));
         chk($sformatf("v%0d_attempts", i), 32'(att0), 32'(vecs[i].att));
         chk($sformatf("v%0d_id", i), id0, vecs[i].id);
         chk($sformatf("v%0d_ts", i), ts0, vecs[i].ts);
         chk($sformatf("v%0d_pairs", i), pairs0 - pair_base, 32'(vecs[i].att) + 32'd1);
         @(posedge clock) #1;
         chk($sformatf("v%0d_hold_done", i), 32'(done0), 32'd1);
         chk($sformatf("v%0d_hold_busy", i), 32'(busy0), 32'd0);
      end

      // start during RD_TS is ignored.
      mode = 0;
      pulse_start0();
      @(posedge clock) #1;
      chk("ign_in_rdts", 32'(addr0), 32'd1);
      start0 = 1'b1;
      @(posedge clock) #1 start0 = 1'b0;
      wait_done0(n);
      chk("ign_latency", n, 32'd2);
      chk("ign_pass", 32'(pass0), 32'd1);
      chk("ign_att", 32'(att0), 32'd0);
      @(posedge clock) #1;
      chk("ign_no_rerun", 32'(busy0), 32'd0);

      // Reset mid RD_TS: outputs clear asynchronously, auto-check reruns.
      pulse_start0();
      @(posedge clock) #1;
      chk("rst_in_rdts", 32'(addr0), 32'd1);
      #2 rst0_n = 1'b0;
      #1 chk_zero0("async_rst");
      @(negedge clock) rst0_n = 1'b1;
      @(posedge clock) #1;
      chk("rerun_busy", 32'(busy0), 32'd1);
      wait_done0(n);
      chk("rerun_latency", n, 32'd4);
      chk("rerun_pass", 32'(pass0), 32'd1);

      // READ_LATENCY=3: address held 4 cycles per word, done 10 cycles in.
      done_k = -1;
      @(negedge clock) rst3_n = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(posedge clock) #1;
         if (k == 0) chk("l3_busy", 32'(busy3), 32'd1);
         chk($sformatf("l3_addr_k%0d", k), 32'(addr3), 32'((k >= 4) && (k < 8)));
         if (done3 && done_k < 0) done_k = k;
      end
      chk("l3_latency", done_k, 32'd10);
      chk("l3_pass", 32'(pass3), 32'd1);
      chk("l3_id", id3, 32'd0);
      chk("l3_ts", ts3, TS_OK);
      chk("l3_att", 32'(att3), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 0, the 32-bit value the system-ID slave SHALL return at address 0.
REQ-002 Parameter EXPECTED_TS, default 1419253882, the 32-bit timestamp the slave SHALL return at address 1.
REQ-003 Parameter READ_LATENCY, default 0, range 0..15, extra cycles the address SHALL be held before readdata is sampled.
REQ-004 Parameter RETRIES, default 2, range 0..7, re-read attempts after a mismatch before failure is declared.
REQ-005 Parameter AUTO_START, default 1, 1 = a check SHALL run once automatically after reset release.
REQ-006 clock  input  1  sole clock; all state SHALL change on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle request to run a check.
REQ-009 sysid_address  output  1  address driven to the system-ID slave (0 = ID, 1 = timestamp).
REQ-010 sysid_readdata  input  32  read data returned by the system-ID slave.
REQ-011 id_value  output  32  last captured address-0 word.
REQ-012 ts_value  output  32  last captured address-1 word.
REQ-013 busy  output  1  high while a check is in progress.
REQ-014 done  output  1  high, held, once a check has completed.
REQ-015 pass  output  1  high with done when both words matched.
REQ-016 fail_id / fail_ts  output  1 each  high with done when the respective word mismatched on the final attempt.
REQ-017 attempts  output  3  number of retries consumed by the last/current check.

Function
REQ-018 FSM states SHALL be IDLE, RD_ID, RD_TS, CHECK, DONE; all outputs SHALL be registered.
REQ-019 IDLE or DONE with start=1 (or IDLE with pending auto-start) SHALL go to RD_ID, clear done/pass/fail_id/fail_ts/attempts, set busy.
REQ-020 start while busy=1 SHALL be ignored; no queuing.
REQ-021 RD_ID SHALL drive sysid_address=0 for READ_LATENCY+1 cycles, capture sysid_readdata into id_value on the last, then go to RD_TS.
REQ-022 RD_TS SHALL drive sysid_address=1 for READ_LATENCY+1 cycles, capture sysid_readdata into ts_value on the last, then go to CHECK.
REQ-023 sysid_address SHALL be 0 in every state except RD_TS.
REQ-024 CHECK SHALL compare all 32 bits of id_value to EXPECTED_ID and ts_value to EXPECTED_TS, one cycle.
REQ-025 CHECK, both equal: go to DONE with pass=1, done=1, busy=0.
REQ-026 CHECK, any mismatch and attempts<RETRIES: increment attempts, return to RD_ID, busy stays 1.
REQ-027 CHECK, any mismatch and attempts=RETRIES: go to DONE with done=1, pass=0, fail_id/fail_ts per final comparison, busy=0.
REQ-028 Latency: done SHALL rise 2*(READ_LATENCY+1)+2 cycles after start is sampled on a first-attempt pass (4 cycles for READ_LATENCY=0).
REQ-029 Each retry SHALL add 2*(READ_LATENCY+1)+1 cycles.
REQ-030 DONE SHALL hold all results until the next accepted start or reset.
REQ-031 pass and any fail flag SHALL never be high together; done=1 implies busy=0.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, sysid_address=0, id_value=0, ts_value=0, busy=0, done=0, pass=0, fail_id=0, fail_ts=0, attempts=0, regardless of state.
REQ-033 Reset mid-check SHALL abandon it with no result reported.
REQ-034 With AUTO_START=1 an auto-start SHALL be armed by reset and consumed on the first IDLE cycle after release; with AUTO_START=0 the block SHALL wait for start.

Verification
REQ-035 Model slave returns 0/1419253882, AUTO_START=1, L=0 -> busy 1st cycle after release, done=1, pass=1 exactly 4 cycles later, attempts=0.
REQ-036 Slave returns ts=1419253881 always, RETRIES=2 -> 3 read pairs, done with pass=0, fail_ts=1, fail_id=0, attempts=2, ts_value=1419253881.
REQ-037 Slave returns ts wrong on first pair only -> one retry, pass=1, attempts=1.
REQ-038 READ_LATENCY=3, slave data valid only 3 cycles after address change -> address held 4 cycles each, correct capture, done 10 cycles after start.
REQ-039 start pulsed during RD_TS -> ignored; second start in DONE -> results cleared, new check runs.
REQ-040 reset_n asserted during RD_TS -> all outputs zero asynchronously; after release auto-check reruns and passes.
